// File: rtl/bf_mem_pkg.sv
// Shared encodings for the bfcpu data-tape memory:
// request opcodes and controller state.
package bf_mem_pkg;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_INC   = 2'b10;
  localparam logic [1:0] OP_DEC   = 2'b11;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'b00,
    ST_IDLE  = 2'b01,
    ST_RMW   = 2'b10
  } state_t;

endpackage

// File: rtl/bf_spram.sv
// Single-port RAM, synchronous read, read-before-write.
// This is the only part intended to map onto block RAM.
module bf_spram #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clka,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dia,
  input  logic              wea,
  output logic [DATA_W-1:0] doa
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clka) begin
    if (wea) mem[addra] <= dia;
    doa <= mem[addra];
  end

endmodule

// File: rtl/bf_data_mem.sv
// Data-tape memory for bfcpu: read/write/inc/dec handshake
// in front of a single-port RAM, with a post-reset zero sweep.
module bf_data_mem
  import bf_mem_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 6,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              clear_busy
);

  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] rmw_addr;
  logic              rmw_dec;
  logic              rsp_sel;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dia;
  logic [DATA_W-1:0] doa;
  logic              wea;
  logic [DATA_W-1:0] nxt;
  logic              accept;

  assign req_ready  = (state == ST_IDLE) && !rsta;
  assign clear_busy = (state == ST_CLEAR);
  assign accept     = req_valid && req_ready;
  assign nxt        = rmw_dec ? doa - ONE : doa + ONE;
  // Read results come straight off the RAM; data_q keeps them afterwards.
  assign rsp_data   = rsp_sel ? doa : data_q;

  always_comb begin
    addra = req_addr;
    dia   = req_wdata;
    wea   = 1'b0;
    case (state)
      ST_CLEAR: begin
        addra = cnt;
        dia   = '0;
        wea   = !rsta;
      end
      ST_IDLE: wea = accept && (req_op == OP_WRITE);
      ST_RMW: begin
        addra = rmw_addr;
        dia   = nxt;
        wea   = !rsta;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      cnt       <= '0;
      rmw_addr  <= '0;
      rmw_dec   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_sel   <= 1'b0;
      data_q    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_sel   <= 1'b0;
      if (rsp_sel) data_q <= doa;
      case (state)
        ST_CLEAR: begin
          cnt <= cnt + ADDR_W'(1);
          if (cnt == '1) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (accept) begin
            case (req_op)
              OP_READ: begin
                rsp_valid <= 1'b1;
                rsp_sel   <= 1'b1;
              end
              OP_WRITE: begin
                rsp_valid <= 1'b1;
                data_q    <= req_wdata;
              end
              default: begin
                rmw_addr <= req_addr;
                rmw_dec  <= (req_op == OP_DEC);
                state    <= ST_RMW;
              end
            endcase
          end
        end
        ST_RMW: begin
          rsp_valid <= 1'b1;
          data_q    <= nxt;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  bf_spram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clka (clka),
    .addra(addra),
    .dia  (dia),
    .wea  (wea),
    .doa  (doa)
  );

endmodule

// File: tb/tb_bf_data_mem.sv
// Directed bench for bf_data_mem: sweep, handshake, wrap,
// mid-op reset, and wide / no-clear parameter sets.
module tb_bf_data_mem;

  localparam logic [1:0] RD  = 2'b00;
  localparam logic [1:0] WR  = 2'b01;
  localparam logic [1:0] INC = 2'b10;
  localparam logic [1:0] DEC = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, valid = 1'b0;
  logic [1:0] op = RD;
  logic [5:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       req_ready, rsp_valid, clear_busy;
  logic [7:0] rsp_data;

  logic        rst16 = 1'b1, v16 = 1'b0;
  logic [1:0]  op16 = RD;
  logic [9:0]  a16 = '0;
  logic [15:0] wd16 = '0;
  logic        rdy16, rv16, busy16;
  logic [15:0] rd16;

  logic       rst0 = 1'b1;
  logic       rdy0, rv0, busy0;
  logic [7:0] rd0;

  int n_checks = 0;
  int n_errors = 0;

  bf_data_mem dut (
    .clka(clk), .rsta(rst),
    .req_valid(valid), .req_ready(req_ready),
    .req_op(op), .req_addr(addr), .req_wdata(wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .clear_busy(clear_busy)
  );

  bf_data_mem #(.DATA_W(16), .ADDR_W(10)) dut16 (
    .clka(clk), .rsta(rst16),
    .req_valid(v16), .req_ready(rdy16),
    .req_op(op16), .req_addr(a16), .req_wdata(wd16),
    .rsp_valid(rv16), .rsp_data(rd16),
    .clear_busy(busy16)
  );

  bf_data_mem #(.CLEAR_ON_RESET(0)) dut0 (
    .clka(clk), .rsta(rst0),
    .req_valid(1'b0), .req_ready(rdy0),
    .req_op(RD), .req_addr(6'd0), .req_wdata(8'd0),
    .rsp_valid(rv0), .rsp_data(rd0),
    .clear_busy(busy0)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Counts cycles with clear_busy high; flags handshake activity meanwhile.
  task automatic sweep(output int n, output int bad);
    n = 0;
    bad = 0;
    while (clear_busy && n < 200) begin
      if (req_ready || rsp_valid) bad++;
      tick;
      n++;
    end
  endtask

  task automatic req(input logic [1:0] o, input logic [5:0] a,
                     input logic [7:0] wd,
                     output logic [7:0] rd, output int lat);
    int t;
    valid = 1'b1;
    op    = o;
    addr  = a;
    wdata = wd;
    t = 0;
    while (!req_ready && t < 100) begin
      tick;
      t++;
    end
    tick;
    valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      tick;
      lat++;
    end
    rd = rsp_data;
  endtask

  initial begin
    logic [7:0] d;
    int lat, n, bad;

    tick;
    tick;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_data", 32'(rsp_data), 32'd0);
    check("rst_busy", 32'(clear_busy), 32'd1);
    rst = 1'b0;
    sweep(n, bad);
    check("sweep_len", 32'(n), 32'd64);
    check("sweep_quiet", 32'(bad), 32'd0);
    check("post_sweep_ready", 32'(req_ready), 32'd1);

    req(RD, 6'd0, 8'h00, d, lat);
    check("rd0", 32'(d), 32'h00);
    req(RD, 6'd31, 8'h00, d, lat);
    check("rd31", 32'(d), 32'h00);
    req(RD, 6'd63, 8'h00, d, lat);
    check("rd63", 32'(d), 32'h00);
    check("rd_lat", 32'(lat), 32'd1);

    // Back-to-back write then read, no bubble.
    valid = 1'b1;
    op = WR;
    addr = 6'd3;
    wdata = 8'h5A;
    tick;
    check("b2b_wr_v", 32'(rsp_valid), 32'd1);
    check("b2b_wr_d", 32'(rsp_data), 32'h5A);
    check("b2b_ready", 32'(req_ready), 32'd1);
    op = RD;
    wdata = 8'h00;
    tick;
    valid = 1'b0;
    check("b2b_rd_v", 32'(rsp_valid), 32'd1);
    check("b2b_rd_d", 32'(rsp_data), 32'h5A);
    tick;
    check("hold_v", 32'(rsp_valid), 32'd0);
    check("hold_d", 32'(rsp_data), 32'h5A);

    // Increment wrap.
    req(WR, 6'd10, 8'hFF, d, lat);
    check("wr10", 32'(d), 32'hFF);
    valid = 1'b1;
    op = INC;
    addr = 6'd10;
    tick;
    valid = 1'b0;
    check("inc_busy_rdy", 32'(req_ready), 32'd0);
    check("inc_busy_v", 32'(rsp_valid), 32'd0);
    tick;
    check("inc_v", 32'(rsp_valid), 32'd1);
    check("inc_wrap", 32'(rsp_data), 32'h00);
    check("inc_rdy_back", 32'(req_ready), 32'd1);
    req(RD, 6'd10, 8'h00, d, lat);
    check("rd10", 32'(d), 32'h00);

    // Plain increment, mid-range.
    req(WR, 6'd11, 8'h41, d, lat);
    req(INC, 6'd11, 8'h00, d, lat);
    check("inc_mid", 32'(d), 32'h42);
    check("inc_lat", 32'(lat), 32'd2);

    // Decrement wrap and repeat.
    req(DEC, 6'd20, 8'h00, d, lat);
    check("dec_wrap", 32'(d), 32'hFF);
    req(DEC, 6'd20, 8'h00, d, lat);
    check("dec_again", 32'(d), 32'hFE);
    req(RD, 6'd20, 8'h00, d, lat);
    check("rd20", 32'(d), 32'hFE);
    req(RD, 6'd3, 8'h00, d, lat);
    check("rd3_kept", 32'(d), 32'h5A);

    // Reset during the RMW cycle of INC 5.
    req(WR, 6'd63, 8'hAA, d, lat);
    req(WR, 6'd5, 8'h07, d, lat);
    check("wr5", 32'(d), 32'h07);
    valid = 1'b1;
    op = INC;
    addr = 6'd5;
    tick;
    valid = 1'b0;
    rst = 1'b1;
    tick;
    check("mid_rst_v", 32'(rsp_valid), 32'd0);
    check("mid_rst_d", 32'(rsp_data), 32'h00);
    check("mid_rst_busy", 32'(clear_busy), 32'd1);
    rst = 1'b0;
    sweep(n, bad);
    check("resweep_len", 32'(n), 32'd64);
    check("resweep_quiet", 32'(bad), 32'd0);
    req(RD, 6'd5, 8'h00, d, lat);
    check("rd5_cleared", 32'(d), 32'h00);
    req(RD, 6'd63, 8'h00, d, lat);
    check("rd63_cleared", 32'(d), 32'h00);

    // Wide instance: 1024-cycle sweep and 16-bit wrap.
    rst16 = 1'b0;
    n = 0;
    while (busy16 && n < 2000) begin
      tick;
      n++;
    end
    check("w_sweep_len", 32'(n), 32'd1024);
    v16 = 1'b1;
    op16 = WR;
    a16 = 10'd1000;
    wd16 = 16'hFFFF;
    tick;
    check("w_wr_v", 32'(rv16), 32'd1);
    check("w_wr_d", 32'(rd16), 32'hFFFF);
    op16 = INC;
    tick;
    v16 = 1'b0;
    check("w_inc_rdy", 32'(rdy16), 32'd0);
    tick;
    check("w_inc_v", 32'(rv16), 32'd1);
    check("w_inc_wrap", 32'(rd16), 32'h0000);

    // No-clear instance: ready straight after release.
    check("nc_rst_rdy", 32'(rdy0), 32'd0);
    check("nc_rst_busy", 32'(busy0), 32'd0);
    rst0 = 1'b0;
    #1;
    check("nc_rdy", 32'(rdy0), 32'd1);
    tick;
    check("nc_rdy_hold", 32'(rdy0), 32'd1);
    check("nc_quiet", 32'(rv0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
